// File: rtl/data_bram_hs.sv
// data_bram_hs: handshaked, byte-strobed single-port data memory.
// In-order responses with configurable read latency and a credit-protected response buffer.
module data_bram_hs #(
    parameter int AW     = 10,
    parameter int DW     = 32,
    parameter int DEPTH  = 2**AW,
    parameter int RD_LAT = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_we,
    input  logic [AW-1:0]   i_req_addr,
    input  logic [DW/8-1:0] i_req_strb,
    input  logic [DW-1:0]   i_req_data,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [DW-1:0]   o_rsp_data,
    output logic            o_rsp_err
);

    localparam int SW  = DW / 8;
    localparam int NB  = RD_LAT + 1;
    localparam int CW  = $clog2(RD_LAT + 2);
    localparam int PW  = $clog2(NB);
    localparam int FCW = $clog2(NB + 1);

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] OUT_MAX = CW'(RD_LAT + 1);
    localparam logic [PW-1:0] PTR_MAX = PW'(NB - 1);

    // storage
    logic [DW-1:0]  mem [DEPTH];
    logic [DW-1:0]  rd_q;

    // request side
    logic [CW-1:0]  out_cnt;
    logic           accept;
    logic           in_range;

    // read pipeline
    logic [RD_LAT-1:0] pv;
    logic [RD_LAT-1:0] pe;
    logic              rd_sel;
    logic [DW-1:0]     d0;
    logic              pipe_v;
    logic              pipe_e;
    logic [DW-1:0]     pipe_d;

    // response buffer
    logic [DW-1:0]  fd [NB];
    logic [NB-1:0]  fe;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [FCW-1:0] f_cnt;
    logic           f_empty;
    logic           f_push;
    logic           f_pop;

    // response side
    logic           rsp_v;
    logic [DW-1:0]  rsp_d;
    logic           rsp_e;
    logic           rsp_hs;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    assign o_req_ready = i_rst_n & (out_cnt < OUT_MAX);
    assign accept      = i_req_valid & o_req_ready;
    assign in_range    = {1'b0, i_req_addr} < DEPTH_W;

    // byte-masked write port; out-of-range addresses never touch the array
    always_ff @(posedge i_clk) begin
        if (accept && i_req_we && in_range) begin
            for (int b = 0; b < SW; b++) begin
                if (i_req_strb[b]) begin
                    mem[i_req_addr][8*b +: 8] <= i_req_data[8*b +: 8];
                end
            end
        end
    end

    // synchronous read register, loaded only by in-range reads
    always_ff @(posedge i_clk) begin
        if (accept && !i_req_we && in_range) begin
            rd_q <= mem[i_req_addr];
        end
    end

    // valid/err/select tags travel alongside the read data
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pv     <= '0;
            pe     <= '0;
            rd_sel <= 1'b0;
        end else begin
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                pe[i] <= pe[i-1];
            end
            pv[0]  <= accept;
            pe[0]  <= accept & ~in_range;
            rd_sel <= accept & ~i_req_we & in_range;
        end
    end

    // writes and errors carry zero data
    assign d0 = rd_sel ? rd_q : '0;

    if (RD_LAT == 1) begin : g_lat1
        assign pipe_d = d0;
    end else begin : g_latn
        logic [DW-1:0] sd [1:RD_LAT-1];

        // extra data stages for latencies above one
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                for (int i = 1; i < RD_LAT; i++) begin
                    sd[i] <= '0;
                end
            end else begin
                sd[1] <= d0;
                for (int i = 2; i < RD_LAT; i++) begin
                    sd[i] <= sd[i-1];
                end
            end
        end

        assign pipe_d = sd[RD_LAT-1];
    end

    assign pipe_v = pv[RD_LAT-1];
    assign pipe_e = pe[RD_LAT-1];

    assign f_empty = (f_cnt == '0);

    // present buffer head first; bypass the pipeline when the buffer is empty
    always_comb begin
        rsp_v = 1'b0;
        rsp_d = '0;
        rsp_e = 1'b0;
        if (!f_empty) begin
            rsp_v = 1'b1;
            rsp_d = fd[rd_ptr];
            rsp_e = fe[rd_ptr];
        end else if (pipe_v) begin
            rsp_v = 1'b1;
            rsp_d = pipe_d;
            rsp_e = pipe_e;
        end
    end

    assign o_rsp_valid = i_rst_n & rsp_v;
    assign o_rsp_data  = o_rsp_valid ? rsp_d : '0;
    assign o_rsp_err   = o_rsp_valid & rsp_e;

    assign rsp_hs = o_rsp_valid & i_rsp_ready;
    assign f_pop  = ~f_empty & rsp_hs;
    assign f_push = pipe_v & ~(f_empty & rsp_hs);

    // buffer payload needs no reset; occupancy is tracked separately
    always_ff @(posedge i_clk) begin
        if (f_push) begin
            fd[wr_ptr] <= pipe_d;
            fe[wr_ptr] <= pipe_e;
        end
    end

    // buffer pointers and occupancy
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            f_cnt  <= '0;
        end else begin
            if (f_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (f_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            f_cnt <= f_cnt + FCW'(f_push) - FCW'(f_pop);
        end
    end

    // outstanding-request credit counter
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            out_cnt <= '0;
        end else begin
            case ({accept, rsp_hs})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bram_hs.sv
// tb_data_bram_hs: directed and scoreboarded bench for data_bram_hs.
// Built with RD_LAT=2 and DEPTH=1000 so latency, credit and range paths all get exercised.
module tb_data_bram_hs;

    localparam int AW     = 10;
    localparam int DW     = 32;
    localparam int SW     = DW / 8;
    localparam int DEPTH  = 1000;
    localparam int RD_LAT = 2;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_req_valid;
    logic          o_req_ready;
    logic          i_req_we;
    logic [AW-1:0] i_req_addr;
    logic [SW-1:0] i_req_strb;
    logic [DW-1:0] i_req_data;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [DW-1:0] o_rsp_data;
    logic          o_rsp_err;

    data_bram_hs #(
        .AW     (AW),
        .DW     (DW),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_we    (i_req_we),
        .i_req_addr  (i_req_addr),
        .i_req_strb  (i_req_strb),
        .i_req_data  (i_req_data),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_data  (o_rsp_data),
        .o_rsp_err   (o_rsp_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
    } exp_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
        int            cyc;
    } rsp_t;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc   = 0;
    exp_t          exp_q [$];
    rsp_t          rsp_q [$];
    int            acc_q [$];
    logic [DW-1:0] ref_mem [1024];
    exp_t          ex;
    logic          stall_p = 1'b0;
    logic [DW-1:0] stall_d;
    logic          stall_e;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // cycle index used to measure accept-to-response latency
    always @(posedge i_clk) cyc <= cyc + 1;

    // scoreboard: reference memory, in-order expectations, hold-while-stalled
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            exp_q.delete();
            stall_p = 1'b0;
        end else begin
            if (stall_p) begin
                chk("hold_valid", o_rsp_valid, 1);
                chk("hold_data", o_rsp_data, stall_d);
                chk("hold_err", o_rsp_err, stall_e);
            end
            stall_p = o_rsp_valid & ~i_rsp_ready;
            stall_d = o_rsp_data;
            stall_e = o_rsp_err;
            if (o_rsp_valid && i_rsp_ready) begin
                rsp_q.push_back('{o_rsp_data, o_rsp_err, cyc});
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", exp_q.size(), 1);
                end else begin
                    ex = exp_q.pop_front();
                    chk("sb_data", o_rsp_data, ex.d);
                    chk("sb_err", o_rsp_err, ex.e);
                end
            end
            if (i_req_valid && o_req_ready) begin
                acc_q.push_back(cyc);
                if (int'(i_req_addr) >= DEPTH) begin
                    exp_q.push_back('{32'h0, 1'b1});
                end else if (i_req_we) begin
                    for (int b = 0; b < SW; b++) begin
                        if (i_req_strb[b]) begin
                            ref_mem[i_req_addr][8*b +: 8] = i_req_data[8*b +: 8];
                        end
                    end
                    exp_q.push_back('{32'h0, 1'b0});
                end else begin
                    exp_q.push_back('{ref_mem[i_req_addr], 1'b0});
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [AW-1:0] a,
                         input logic [SW-1:0] s, input logic [DW-1:0] d,
                         input bit rnd_rdy);
        int   n = 0;
        logic r;
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_addr  = a;
        i_req_strb  = s;
        i_req_data  = d;
        do begin
            @(negedge i_clk);
            r = o_req_ready;
            @(posedge i_clk);
            #1;
            if (rnd_rdy) i_rsp_ready = ($urandom_range(0, 3) != 0);
            n++;
        end while (!r && n < 100);
        if (!r) chk("req_timeout", n, 0);
        i_req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic wait_rsp(input int want, input string tag);
        int n = 0;
        while (rsp_q.size() < want && n < 300) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        chk(tag, rsp_q.size(), want);
    endtask

    task automatic clr_logs();
        rsp_q.delete();
        acc_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] ba;
        logic          acc;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;

        // reset with traffic applied
        i_rst_n     = 1'b0;
        i_req_valid = 1'b1;
        i_req_we    = 1'b1;
        i_req_addr  = 10'd3;
        i_req_strb  = '1;
        i_req_data  = 32'hFFFF_FFFF;
        i_rsp_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_req_ready", o_req_ready, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_rsp_data", o_rsp_data, 0);
        chk("rst_rsp_err", o_rsp_err, 0);
        @(posedge i_clk);
        #1;
        i_rst_n     = 1'b1;
        i_req_valid = 1'b0;
        @(negedge i_clk);
        chk("post_rst_ready", o_req_ready, 1);
        chk("post_rst_rsp_valid", o_rsp_valid, 0);
        @(posedge i_clk);
        #1;

        // zero the locations the bench reads
        clr_logs();
        for (int a = 0; a < 32; a++) issue(1'b1, AW'(a), 4'hF, 32'h0, 1'b0);
        for (int a = 990; a < 1000; a++) issue(1'b1, AW'(a), 4'hF, 32'h0, 1'b0);
        wait_rsp(42, "preload_rsps");
        idle(2);

        // full write, partial byte write, read back; latency and throughput
        clr_logs();
        issue(1'b1, 10'd5, 4'hF, 32'hDEAD_BEEF, 1'b0);
        issue(1'b1, 10'd5, 4'h1, 32'h0000_00AA, 1'b0);
        issue(1'b0, 10'd5, 4'h0, 32'h0, 1'b0);
        wait_rsp(3, "rmw_count");
        chk("rmw_w1_data", rsp_q[0].d, 32'h0);
        chk("rmw_w2_data", rsp_q[1].d, 32'h0);
        chk("rmw_rd_data", rsp_q[2].d, 32'hDEAD_BEAA);
        chk("rmw_rd_err", rsp_q[2].e, 0);
        for (int i = 0; i < 3; i++) chk("rmw_latency", rsp_q[i].cyc - acc_q[i], RD_LAT);
        chk("rmw_throughput", acc_q[2] - acc_q[0], 2);
        idle(2);

        // credit limit with the response side stalled
        issue(1'b1, 10'd10, 4'hF, 32'h1111_1111, 1'b0);
        issue(1'b1, 10'd11, 4'hF, 32'h2222_2222, 1'b0);
        issue(1'b1, 10'd12, 4'hF, 32'h3333_3333, 1'b0);
        idle(4);
        clr_logs();
        i_rsp_ready = 1'b0;
        i_req_we    = 1'b0;
        i_req_strb  = '0;
        i_req_valid = 1'b1;
        ba          = 10'd10;
        for (int k = 0; k < 6; k++) begin
            i_req_addr = ba;
            @(negedge i_clk);
            acc = o_req_ready;
            @(posedge i_clk);
            #1;
            if (acc) ba = ba + 1'b1;
        end
        i_req_valid = 1'b0;
        chk("bp_accepts", acc_q.size(), 3);
        @(negedge i_clk);
        chk("bp_ready_low", o_req_ready, 0);
        chk("bp_stall_valid", o_rsp_valid, 1);
        chk("bp_stall_data", o_rsp_data, 32'h1111_1111);
        @(posedge i_clk);
        #1;
        i_rsp_ready = 1'b1;
        wait_rsp(3, "bp_count");
        chk("bp_rsp0", rsp_q[0].d, 32'h1111_1111);
        chk("bp_rsp1", rsp_q[1].d, 32'h2222_2222);
        chk("bp_rsp2", rsp_q[2].d, 32'h3333_3333);
        idle(2);

        // out-of-range accesses; no aliasing into the array
        clr_logs();
        issue(1'b1, 10'd1000, 4'hF, 32'h0000_1234, 1'b0);
        issue(1'b0, 10'd1000, 4'h0, 32'h0, 1'b0);
        issue(1'b0, 10'd1023, 4'h0, 32'h0, 1'b0);
        issue(1'b0, 10'd8, 4'h0, 32'h0, 1'b0);
        issue(1'b0, 10'd0, 4'h0, 32'h0, 1'b0);
        wait_rsp(5, "oor_count");
        chk("oor_wr_err", rsp_q[0].e, 1);
        chk("oor_wr_data", rsp_q[0].d, 32'h0);
        chk("oor_rd_err", rsp_q[1].e, 1);
        chk("oor_rd_data", rsp_q[1].d, 32'h0);
        chk("oor_top_err", rsp_q[2].e, 1);
        chk("inr_8_err", rsp_q[3].e, 0);
        chk("inr_8_data", rsp_q[3].d, 32'h0);
        chk("inr_0_data", rsp_q[4].d, 32'h0);
        idle(2);

        // random stream against the reference model
        clr_logs();
        for (int k = 0; k < 256; k++) begin
            logic [AW-1:0] a;
            if ($urandom_range(0, 3) == 0) a = AW'(995 + $urandom_range(0, 28));
            else a = AW'($urandom_range(0, 15));
            issue(1'($urandom_range(0, 1)), a, SW'($urandom_range(0, 15)),
                  $urandom, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge i_clk);
                #1;
                i_rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
        i_rsp_ready = 1'b1;
        wait_rsp(256, "stream_rsps");
        chk("stream_accepts", acc_q.size(), 256);
        chk("stream_pending", exp_q.size(), 0);
        idle(2);

        // reset with two requests outstanding
        clr_logs();
        i_rsp_ready = 1'b0;
        issue(1'b1, 10'd20, 4'hF, 32'h5A5A_5A5A, 1'b0);
        issue(1'b0, 10'd20, 4'h0, 32'h0, 1'b0);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        chk("midrst_valid", o_rsp_valid, 0);
        chk("midrst_ready", o_req_ready, 0);
        idle(2);
        i_rst_n     = 1'b1;
        i_rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            chk("no_stale_valid", o_rsp_valid, 0);
            @(posedge i_clk);
            #1;
        end
        chk("rst_no_rsp", rsp_q.size(), 0);
        issue(1'b0, 10'd20, 4'h0, 32'h0, 1'b0);
        wait_rsp(1, "rst_read_count");
        chk("rst_kept_write", rsp_q[0].d, 32'h5A5A_5A5A);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
